// File: rtl/dsp_chain_pkg.sv
// Shared types and helpers for the integer SOP DSP chain.
// Holds chain widths, the accumulator state encoding and the overflow classifier.
package dsp_chain_pkg;

  localparam int CHAIN_RES_W = 37;
  localparam int ACC_W_DEF   = 48;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic {ST_IDLE, ST_ACCUM} acc_state_e;

  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_kind_e;

  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] data;
    logic [CNT_W_DEF-1:0]        beats;
    logic                        sat;
  } sop_entry_t;

  // Classifies an ACC_W+1 sum from its top two bits: 01 ran past +max, 10 past -min.
  function automatic sat_kind_e sat_kind(input logic [1:0] top2);
    case (top2)
      2'b01:   return SAT_POS;
      2'b10:   return SAT_NEG;
      default: return SAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dsp_chain_sop_drain_if.sv
// Handshake bundle between the SOP chain tail, the drain block and its consumer.
// The slave side is the drain; the master side is whoever drives the chain and consumes totals.
interface dsp_chain_sop_drain_if #(
  parameter int IN_W  = 37,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic                    in_last;
  logic signed [IN_W-1:0]  in_result;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [CNT_W-1:0]        out_beats;
  logic                    out_sat;
  logic                    overflow_err;
  logic [CW-1:0]           count;

  modport master (
    output in_valid, in_last, in_result, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_sat, overflow_err, count
  );

  modport slave (
    input  in_valid, in_last, in_result, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_sat, overflow_err, count
  );
endinterface

// File: rtl/sop_result_fifo.sv
// Synchronous result FIFO: head read from registers only, push+pop allowed even when full.
// Also produces the registered early-warning ready and the sticky drop flag.
module sop_result_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  parameter int SKID  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic [CW-1:0]    count_nxt;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & pop_req;
  // When full and popping, wr_ptr equals rd_ptr: the slot being vacated takes the new entry.
  assign push_ok   = push & (~full | pop);
  assign count_nxt = count + CW'(push_ok) - CW'(pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (DEPTH - int'(count_nxt)) > SKID;
      if (push & ~push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dsp_chain_sop_drain.sv
// Tail of the SOP chain: folds beats into per-group totals and queues them for a consumer.
// The chain cannot stall, so in_ready is only advisory and drops are flagged via overflow_err.
module dsp_chain_sop_drain
  import dsp_chain_pkg::*;
#(
  parameter int IN_W     = CHAIN_RES_W,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int DEPTH    = 8,
  parameter int SKID     = 4,
  parameter int SATURATE = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  dsp_chain_sop_drain_if.slave  bus
);
  localparam int EW = ACC_W + CNT_W + 1;

  acc_state_e              state_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0]        beats_p0;
  logic                    sat_p0;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] base;
  logic [ACC_W:0]          sum_wide;
  sat_kind_e               kind;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        beats_base;
  logic [CNT_W-1:0]        beats_nxt;
  logic                    sat_nxt;
  logic                    push;
  logic [EW-1:0]           head;

  function automatic logic signed [ACC_W-1:0] clamp(input logic [ACC_W:0] s, input sat_kind_e k);
    if (SATURATE == 0 || k == SAT_NONE) return s[ACC_W-1:0];
    if (k == SAT_POS) return {1'b0, {(ACC_W-1){1'b1}}};
    return {1'b1, {(ACC_W-1){1'b0}}};
  endfunction

  always_comb begin
    in_ext     = {{(ACC_W-IN_W){bus.in_result[IN_W-1]}}, bus.in_result};
    base       = (state_p0 == ST_ACCUM) ? acc_p0 : '0;
    sum_wide   = {base[ACC_W-1], base} + {in_ext[ACC_W-1], in_ext};
    kind       = sat_kind(sum_wide[ACC_W -: 2]);
    sum        = clamp(sum_wide, kind);
    beats_base = (state_p0 == ST_ACCUM) ? beats_p0 : '0;
    beats_nxt  = (&beats_base) ? beats_base : beats_base + CNT_W'(1);
    sat_nxt    = ((state_p0 == ST_ACCUM) & sat_p0) | (kind != SAT_NONE);
  end

  assign push = bus.in_valid & bus.in_last;

  // Stage p0: open-group accumulator; a closing beat hands its total to the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= ST_IDLE;
      acc_p0   <= '0;
      beats_p0 <= '0;
      sat_p0   <= 1'b0;
    end else if (bus.in_valid) begin
      if (bus.in_last) begin
        state_p0 <= ST_IDLE;
        acc_p0   <= '0;
        beats_p0 <= '0;
        sat_p0   <= 1'b0;
      end else begin
        state_p0 <= ST_ACCUM;
        acc_p0   <= sum;
        beats_p0 <= beats_nxt;
        sat_p0   <= sat_nxt;
      end
    end
  end

  sop_result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .SKID  (SKID)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({sum, beats_nxt, sat_nxt}),
    .pop_req   (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (head),
    .count     (bus.count),
    .ready     (bus.in_ready),
    .overflow  (bus.overflow_err)
  );

  assign {bus.out_data, bus.out_beats, bus.out_sat} = head;

endmodule

// File: tb/tb_dsp_chain_sop_drain.sv
// Directed bench for dsp_chain_sop_drain: a default 48-bit instance plus 40-bit
// saturating and wrapping instances fed identical beats.
module tb_dsp_chain_sop_drain;
  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  dsp_chain_sop_drain_if #(.IN_W(37), .ACC_W(48), .CNT_W(16), .DEPTH(8)) m ();
  dsp_chain_sop_drain_if #(.IN_W(37), .ACC_W(40), .CNT_W(4),  .DEPTH(8)) s ();
  dsp_chain_sop_drain_if #(.IN_W(37), .ACC_W(40), .CNT_W(4),  .DEPTH(8)) w ();

  dsp_chain_sop_drain #(.ACC_W(48), .SATURATE(1), .CNT_W(16)) u_m (.clk(clk), .reset(reset), .bus(m.slave));
  dsp_chain_sop_drain #(.ACC_W(40), .SATURATE(1), .CNT_W(4))  u_s (.clk(clk), .reset(reset), .bus(s.slave));
  dsp_chain_sop_drain #(.ACC_W(40), .SATURATE(0), .CNT_W(4))  u_w (.clk(clk), .reset(reset), .bus(w.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_m(input logic last, input logic signed [36:0] val);
    m.in_valid  = 1'b1;
    m.in_last   = last;
    m.in_result = val;
    tick();
    m.in_valid  = 1'b0;
    m.in_last   = 1'b0;
  endtask

  task automatic send_40(input logic last, input logic signed [36:0] val);
    s.in_valid = 1'b1; s.in_last = last; s.in_result = val;
    w.in_valid = 1'b1; w.in_last = last; w.in_result = val;
    tick();
    s.in_valid = 1'b0; s.in_last = 1'b0;
    w.in_valid = 1'b0; w.in_last = 1'b0;
  endtask

  task automatic pop_40();
    s.out_ready = 1'b1;
    w.out_ready = 1'b1;
    tick();
    s.out_ready = 1'b0;
    w.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m.in_valid = 1'b0; m.in_last = 1'b0; m.in_result = '0; m.out_ready = 1'b0;
    s.in_valid = 1'b0; s.in_last = 1'b0; s.in_result = '0; s.out_ready = 1'b0;
    w.in_valid = 1'b0; w.in_last = 1'b0; w.in_result = '0; w.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(m.out_valid), 64'(0));
    chk("rst_out_data",  64'(m.out_data),  64'(0));
    chk("rst_out_beats", 64'(m.out_beats), 64'(0));
    chk("rst_out_sat",   64'(m.out_sat),   64'(0));
    chk("rst_count",     64'(m.count),     64'(0));
    chk("rst_in_ready",  64'(m.in_ready),  64'(1));
    chk("rst_overflow",  64'(m.overflow_err), 64'(0));
    reset = 1'b0;

    // Three-beat group 10 + -3 + 100
    send_m(1'b0, 37'sd10);
    chk("g3_mid_valid", 64'(m.out_valid), 64'(0));
    send_m(1'b0, -37'sd3);
    send_m(1'b1, 37'sd100);
    chk("g3_valid", 64'(m.out_valid), 64'(1));
    chk("g3_data",  64'(m.out_data),  64'(107));
    chk("g3_beats", 64'(m.out_beats), 64'(3));
    chk("g3_sat",   64'(m.out_sat),   64'(0));
    chk("g3_count", 64'(m.count),     64'(1));
    tick();
    tick();
    chk("g3_hold_data",  64'(m.out_data),  64'(107));
    chk("g3_hold_valid", 64'(m.out_valid), 64'(1));
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    chk("g3_pop_count", 64'(m.count),     64'(0));
    chk("g3_pop_valid", 64'(m.out_valid), 64'(0));

    // Single-beat negative group with consumer already ready
    m.out_ready = 1'b1;
    send_m(1'b1, -37'sd5);
    chk("g1_valid", 64'(m.out_valid), 64'(1));
    chk("g1_data",  64'(m.out_data),  64'(-5));
    chk("g1_beats", 64'(m.out_beats), 64'(1));
    tick();
    chk("g1_pop_count", 64'(m.count), 64'(0));
    m.out_ready = 1'b0;

    // Fill past capacity with no consumer
    for (int k = 1; k <= 9; k++) begin
      send_m(1'b1, 37'(k));
      chk("fill_count",    64'(m.count),        64'((k > 8) ? 8 : k));
      chk("fill_in_ready", 64'(m.in_ready),     64'(k < 4));
      chk("fill_overflow", 64'(m.overflow_err), 64'(k == 9));
    end
    m.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data",  64'(m.out_data),  64'(i));
      chk("drain_beats", 64'(m.out_beats), 64'(1));
      tick();
    end
    m.out_ready = 1'b0;
    chk("drain_count",    64'(m.count),        64'(0));
    chk("drain_in_ready", 64'(m.in_ready),     64'(1));
    chk("drain_sticky",   64'(m.overflow_err), 64'(1));

    // Push and pop together while full
    pulse_reset();
    chk("clr_overflow", 64'(m.overflow_err), 64'(0));
    for (int k = 0; k < 8; k++) send_m(1'b1, 37'(11 + k));
    chk("full_count", 64'(m.count), 64'(8));
    m.out_ready = 1'b1;
    send_m(1'b1, 37'sd99);
    chk("pp_count",    64'(m.count),        64'(8));
    chk("pp_overflow", 64'(m.overflow_err), 64'(0));
    chk("pp_head",     64'(m.out_data),     64'(12));
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain", 64'(m.out_data), 64'((i < 7) ? 12 + i : 99));
      tick();
    end
    m.out_ready = 1'b0;
    chk("pp_empty", 64'(m.count), 64'(0));

    // Reset in the middle of a group discards the partial sum
    send_m(1'b0, 37'sd5);
    send_m(1'b0, 37'sd6);
    pulse_reset();
    chk("mid_rst_count", 64'(m.count), 64'(0));
    send_m(1'b1, 37'sd7);
    chk("mid_rst_data",  64'(m.out_data),  64'(7));
    chk("mid_rst_beats", 64'(m.out_beats), 64'(1));
    chk("mid_rst_sat",   64'(m.out_sat),   64'(0));

    // 40-bit positive overflow: 9 * (2^36-1)
    for (int k = 1; k <= 9; k++) send_40(k == 9, 37'sh0FFFFFFFFF);
    chk("pos_sat_data",  64'(s.out_data),  64'(40'sh7FFFFFFFFF));
    chk("pos_sat_flag",  64'(s.out_sat),   64'(1));
    chk("pos_sat_beats", 64'(s.out_beats), 64'(9));
    chk("pos_wrap_data", 64'(w.out_data),  64'(40'sh8FFFFFFFF7));
    chk("pos_wrap_flag", 64'(w.out_sat),   64'(1));
    pop_40();

    // 40-bit negative overflow: 9 * (-2^36)
    for (int k = 1; k <= 9; k++) send_40(k == 9, 37'sh1000000000);
    chk("neg_sat_data",  64'(s.out_data), 64'(40'sh8000000000));
    chk("neg_sat_flag",  64'(s.out_sat),  64'(1));
    chk("neg_wrap_data", 64'(w.out_data), 64'(40'sh7000000000));
    chk("neg_wrap_flag", 64'(w.out_sat),  64'(1));
    pop_40();

    // Just below the positive limit: no overflow
    for (int k = 1; k <= 8; k++) send_40(k == 8, 37'sh0FFFFFFFFF);
    chk("edge_sat_data",  64'(s.out_data), 64'(40'sh7FFFFFFFF8));
    chk("edge_sat_flag",  64'(s.out_sat),  64'(0));
    chk("edge_wrap_data", 64'(w.out_data), 64'(40'sh7FFFFFFFF8));
    pop_40();

    // Beat counter sticks at all-ones on a 4-bit counter
    for (int k = 1; k <= 20; k++) send_40(k == 20, 37'sd1);
    chk("cnt_sat_beats", 64'(s.out_beats), 64'(15));
    chk("cnt_sat_data",  64'(s.out_data),  64'(20));
    chk("cnt_sat_flag",  64'(s.out_sat),   64'(0));
    pop_40();
    chk("cnt_pop_count", 64'(s.count), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
